// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM states.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_lite_regbank.sv
// Byte-strobed register array with one write port, one asynchronous read
// port and a flat view of every slot for the IP core.
module axi_lite_regbank #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NSLOT = 15,
  parameter int unsigned IW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [IW-1:0]       wr_idx_i,
  input  logic [DW-1:0]       wr_data_i,
  input  logic [DW/8-1:0]     wr_strb_i,
  input  logic [IW-1:0]       rd_idx_i,
  output logic [DW-1:0]       rd_data_o,
  output logic [NSLOT*DW-1:0] flat_o
);

  logic [DW-1:0] mem_q [NSLOT];

  // Slot storage: only strobed bytes of the addressed slot change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSLOT; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int unsigned k = 0; k < DW/8; k++) begin
        if (wr_strb_i[k]) mem_q[wr_idx_i][k*8 +: 8] <= wr_data_i[k*8 +: 8];
      end
    end
  end

  // Asynchronous read; indices past the last slot read as zero.
  always_comb begin
    rd_data_o = '0;
    if (rd_idx_i < IW'(NSLOT)) rd_data_o = mem_q[rd_idx_i];
  end

  // Flatten slots so slot i sits at bits [i*DW +: DW].
  always_comb begin
    flat_o = '0;
    for (int unsigned i = 0; i < NSLOT; i++) flat_o[i*DW +: DW] = mem_q[i];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder exposing a control/status register bank. Independent
// write and read FSMs, one outstanding transaction per direction.
module axi4_lite_slave_regs #(
  parameter int unsigned data_width = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 AWvalid,
  output logic                                 AWready,
  input  logic [31:0]                          AWaddr,
  input  logic                                 Wvalid,
  output logic                                 Wready,
  input  logic [data_width-1:0]                Wdata,
  input  logic [data_width/8-1:0]              Wstrb,
  output logic                                 Bvalid,
  input  logic                                 Bready,
  output logic [1:0]                           Bresp,
  input  logic                                 ARvalid,
  output logic                                 ARready,
  input  logic [31:0]                          ARaddr,
  output logic                                 Rvalid,
  input  logic                                 Rready,
  output logic [data_width-1:0]                Rdata,
  output logic [1:0]                           Rresp,
  output logic [(NUM_REGS-1)*data_width-1:0]   Reg_Out,
  input  logic [data_width-1:0]                Status_In,
  output logic                                 Wr_Pulse,
  output logic [$clog2(NUM_REGS)-1:0]          Wr_Index
);

  import axi_lite_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned NSLOT = NUM_REGS - 1;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NSLOT);

  wr_state_e                 wstate_q;
  logic                      aw_held_q, w_held_q;
  logic [31:0]               awaddr_q;
  logic [data_width-1:0]     wdata_q;
  logic [data_width/8-1:0]   wstrb_q;
  logic                      awready_q, wready_q, bvalid_q;
  logic [1:0]                bresp_q;
  logic                      wr_pulse_q;
  logic [IDX_W-1:0]          wr_index_q;

  rd_state_e                 rstate_q;
  logic                      arready_q, rvalid_q;
  logic [data_width-1:0]     rdata_q;
  logic [1:0]                rresp_q;

  logic                      aw_hs, w_hs, aw_have, w_have, commit;
  logic [31:0]               cm_addr;
  logic [data_width-1:0]     cm_data;
  logic [data_width/8-1:0]   cm_strb;
  logic [IDX_W-1:0]          cm_idx, ar_idx;
  logic                      cm_ok, bank_we, ar_oor;
  logic [1:0]                bresp_d, rresp_d;
  logic [data_width-1:0]     bank_rdata, rdata_d;
  logic                      unused_addr_bits;

  // Write-side decode: a held beat wins over the live bus, so a commit can
  // use whichever of AW/W arrived earlier plus the one handshaking now.
  always_comb begin
    aw_hs    = AWvalid & awready_q;
    w_hs     = Wvalid & wready_q;
    aw_have  = aw_held_q | aw_hs;
    w_have   = w_held_q | w_hs;
    commit   = (wstate_q == W_IDLE) & aw_have & w_have;
    cm_addr  = aw_held_q ? awaddr_q : AWaddr;
    cm_data  = w_held_q ? wdata_q : Wdata;
    cm_strb  = w_held_q ? wstrb_q : Wstrb;
    cm_idx   = cm_addr[IDX_W+1:2];
    cm_ok    = ~(|cm_addr[31:IDX_W+2]) & (cm_idx != STATUS_IDX);
    bank_we  = commit & cm_ok;
    bresp_d  = cm_ok ? RESP_OKAY : RESP_SLVERR;
    unused_addr_bits = ^{cm_addr[1:0], ARaddr[1:0]};
  end

  // Read-side decode and response mux.
  always_comb begin
    ar_idx  = ARaddr[IDX_W+1:2];
    ar_oor  = |ARaddr[31:IDX_W+2];
    rdata_d = bank_rdata;
    rresp_d = RESP_OKAY;
    if (ar_oor) begin
      rdata_d = '0;
      rresp_d = RESP_SLVERR;
    end else if (ar_idx == STATUS_IDX) begin
      rdata_d = Status_In;
    end
  end

  axi_lite_regbank #(
    .DW    (data_width),
    .NSLOT (NSLOT),
    .IW    (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst       (reset),
    .we_i      (bank_we),
    .wr_idx_i  (cm_idx),
    .wr_data_i (cm_data),
    .wr_strb_i (cm_strb),
    .rd_idx_i  (ar_idx),
    .rd_data_o (bank_rdata),
    .flat_o    (Reg_Out)
  );

  // Write FSM: collect AW and W in any order, commit, then hold B until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q   <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      wr_pulse_q <= 1'b0;
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) awaddr_q <= AWaddr;
          if (w_hs) begin
            wdata_q <= Wdata;
            wstrb_q <= Wstrb;
          end
          if (commit) begin
            wstate_q  <= W_RESP;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= bresp_d;
            if (cm_ok) begin
              wr_pulse_q <= 1'b1;
              wr_index_q <= cm_idx;
            end
          end else begin
            aw_held_q <= aw_have;
            w_held_q  <= w_have;
            awready_q <= ~aw_have;
            wready_q  <= ~w_have;
          end
        end
        W_RESP: begin
          if (Bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: register data on AR handshake, hold it until R is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ARvalid && arready_q) begin
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (Rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign AWready  = awready_q;
  assign Wready   = wready_q;
  assign Bvalid   = bvalid_q;
  assign Bresp    = bresp_q;
  assign ARready  = arready_q;
  assign Rvalid   = rvalid_q;
  assign Rdata    = rdata_q;
  assign Rresp    = rresp_q;
  assign Wr_Pulse = wr_pulse_q;
  assign Wr_Index = wr_index_q;

endmodule
